// File: rtl/prf_multiport.sv
// Physical register file with registered multi-port reads, same-cycle write/allocate bypass
// and a per-register ready (scoreboard) bit. Register 0 is hardwired to zero / ready.
module prf_multiport #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_PREGS = 64,
  parameter int unsigned NUM_RD    = 4,
  parameter int unsigned NUM_WR    = 2,
  parameter int unsigned NUM_ALLOC = 2,
  localparam int unsigned ADDR_W   = $clog2(NUM_PREGS)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_RD*ADDR_W-1:0]    rd_addr,
  output logic [NUM_RD*DATA_W-1:0]    rd_data,
  output logic [NUM_RD-1:0]           rd_ready,
  input  logic [NUM_WR-1:0]           wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]    wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]    wr_data,
  input  logic [NUM_ALLOC-1:0]        alloc_en,
  input  logic [NUM_ALLOC*ADDR_W-1:0] alloc_addr
);

  logic [DATA_W-1:0]        mem_q [NUM_PREGS];
  logic [NUM_PREGS-1:0]     ready_q;
  logic [NUM_RD*DATA_W-1:0] byp_data;
  logic [NUM_RD-1:0]        byp_ready;

  // Post-update view per read port: later write ports override earlier ones, allocates override writes.
  always_comb begin
    byp_data  = '0;
    byp_ready = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      byp_data[i*DATA_W +: DATA_W] = mem_q[rd_addr[i*ADDR_W +: ADDR_W]];
      byp_ready[i]                 = ready_q[rd_addr[i*ADDR_W +: ADDR_W]];
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == rd_addr[i*ADDR_W +: ADDR_W])) begin
          byp_data[i*DATA_W +: DATA_W] = wr_data[j*DATA_W +: DATA_W];
          byp_ready[i]                 = 1'b1;
        end
      end
      for (int unsigned k = 0; k < NUM_ALLOC; k++) begin
        if (alloc_en[k] && (alloc_addr[k*ADDR_W +: ADDR_W] == rd_addr[i*ADDR_W +: ADDR_W])) begin
          byp_ready[i] = 1'b0;
        end
      end
      if (rd_addr[i*ADDR_W +: ADDR_W] == '0) begin
        byp_data[i*DATA_W +: DATA_W] = '0;
        byp_ready[i]                 = 1'b1;
      end
    end
  end

  // Storage update; NBA ordering gives highest write port and then allocates the final say.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned p = 0; p < NUM_PREGS; p++) begin
        mem_q[p] <= '0;
      end
      ready_q <= '1;
    end else begin
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] != '0)) begin
          mem_q[wr_addr[j*ADDR_W +: ADDR_W]]   <= wr_data[j*DATA_W +: DATA_W];
          ready_q[wr_addr[j*ADDR_W +: ADDR_W]] <= 1'b1;
        end
      end
      for (int unsigned k = 0; k < NUM_ALLOC; k++) begin
        if (alloc_en[k] && (alloc_addr[k*ADDR_W +: ADDR_W] != '0)) begin
          ready_q[alloc_addr[k*ADDR_W +: ADDR_W]] <= 1'b0;
        end
      end
    end
  end

  // Registered read outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_data  <= '0;
      rd_ready <= '1;
    end else begin
      rd_data  <= byp_data;
      rd_ready <= byp_ready;
    end
  end

endmodule

// File: tb/tb_prf_multiport.sv
// Directed self-checking bench for prf_multiport: reset, bypass, port priority,
// scoreboard allocate/writeback and register-0 guarding.
module tb_prf_multiport;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned NUM_PREGS = 64;
  localparam int unsigned NUM_RD    = 4;
  localparam int unsigned NUM_WR    = 2;
  localparam int unsigned NUM_ALLOC = 2;
  localparam int unsigned ADDR_W    = 6;

  logic                        clk = 1'b0;
  logic                        reset_n;
  logic [NUM_RD*ADDR_W-1:0]    rd_addr;
  logic [NUM_RD*DATA_W-1:0]    rd_data;
  logic [NUM_RD-1:0]           rd_ready;
  logic [NUM_WR-1:0]           wr_en;
  logic [NUM_WR*ADDR_W-1:0]    wr_addr;
  logic [NUM_WR*DATA_W-1:0]    wr_data;
  logic [NUM_ALLOC-1:0]        alloc_en;
  logic [NUM_ALLOC*ADDR_W-1:0] alloc_addr;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  prf_multiport #(
    .DATA_W(DATA_W), .NUM_PREGS(NUM_PREGS), .NUM_RD(NUM_RD),
    .NUM_WR(NUM_WR), .NUM_ALLOC(NUM_ALLOC)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    alloc_en = '0;
    alloc_addr = '0;
    rd_addr  = '0;
  endtask

  task automatic rd_all(input logic [ADDR_W-1:0] a);
    for (int i = 0; i < int'(NUM_RD); i++) rd_addr[i*ADDR_W +: ADDR_W] = a;
  endtask

  task automatic wr(input int j, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_en[j] = 1'b1;
    wr_addr[j*ADDR_W +: ADDR_W] = a;
    wr_data[j*DATA_W +: DATA_W] = d;
  endtask

  task automatic alloc(input int k, input logic [ADDR_W-1:0] a);
    alloc_en[k] = 1'b1;
    alloc_addr[k*ADDR_W +: ADDR_W] = a;
  endtask

  // Apply current inputs across one posedge, then settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_port(input string tag, input int i, input logic [31:0] d, input logic r);
    check({tag, "_data"}, rd_data[i*DATA_W +: DATA_W], d);
    check({tag, "_rdy"}, 32'(rd_ready[i]), 32'(r));
  endtask

  task automatic check_all(input string tag, input logic [31:0] d, input logic r);
    for (int i = 0; i < int'(NUM_RD); i++) check_port($sformatf("%s_p%0d", tag, i), i, d, r);
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    wr(0, 6'd5, 32'h1111_1111);
    wr(1, 6'd5, 32'h2222_2222);
    rd_all(6'd5);
    step();
    check_all("rst1", 32'h0, 1'b1);
    step();
    check_all("rst2", 32'h0, 1'b1);

    // First cycle out of reset: p5 must hold its reset value.
    reset_n = 1'b1;
    idle();
    rd_all(6'd5);
    step();
    check_all("rst_p5", 32'h0, 1'b1);

    // Basic write then read on all ports.
    idle();
    wr(0, 6'd7, 32'hDEAD_BEEF);
    step();
    idle();
    rd_all(6'd7);
    step();
    check_all("rw_p7", 32'hDEAD_BEEF, 1'b1);

    // Same-cycle bypass with two writers; port 1 wins.
    idle();
    wr(0, 6'd9, 32'h11);
    wr(1, 6'd9, 32'h22);
    rd_addr[0*ADDR_W +: ADDR_W] = 6'd9;
    rd_addr[2*ADDR_W +: ADDR_W] = 6'd7;
    step();
    check_port("byp_p9", 0, 32'h22, 1'b1);
    check_port("byp_other", 2, 32'hDEAD_BEEF, 1'b1);
    idle();
    rd_addr[1*ADDR_W +: ADDR_W] = 6'd9;
    step();
    check_port("later_p9", 1, 32'h22, 1'b1);

    // Scoreboard: allocate clears ready, writeback sets it with bypass.
    idle();
    alloc(0, 6'd12);
    step();
    idle();
    rd_addr[3*ADDR_W +: ADDR_W] = 6'd12;
    step();
    check_port("sb_busy", 3, 32'h0, 1'b0);
    idle();
    step();
    wr(1, 6'd12, 32'h5);
    rd_addr[3*ADDR_W +: ADDR_W] = 6'd12;
    step();
    check_port("sb_wb", 3, 32'h5, 1'b1);

    // Allocate and write same address same cycle: data lands, ready stays 0.
    idle();
    alloc(1, 6'd20);
    wr(0, 6'd20, 32'hAA);
    rd_addr[0*ADDR_W +: ADDR_W] = 6'd20;
    step();
    check_port("aw_byp", 0, 32'hAA, 1'b0);
    idle();
    rd_addr[2*ADDR_W +: ADDR_W] = 6'd20;
    step();
    check_port("aw_later", 2, 32'hAA, 1'b0);

    // Double allocate of one address plus write from port 1.
    idle();
    alloc(0, 6'd40);
    alloc(1, 6'd40);
    wr(1, 6'd40, 32'h4040);
    rd_addr[1*ADDR_W +: ADDR_W] = 6'd40;
    step();
    check_port("dalloc", 1, 32'h4040, 1'b0);

    // Register 0 guard.
    idle();
    wr(0, 6'd0, 32'hFFFF_FFFF);
    wr(1, 6'd0, 32'hFFFF_FFFF);
    alloc(0, 6'd0);
    alloc(1, 6'd0);
    rd_all(6'd0);
    step();
    check_all("p0_byp", 32'h0, 1'b1);
    idle();
    rd_all(6'd0);
    step();
    check_all("p0_later", 32'h0, 1'b1);

    // Back-to-back writes to one address, each read sees its own cycle's write.
    idle();
    wr(0, 6'd30, 32'h1);
    rd_addr[0*ADDR_W +: ADDR_W] = 6'd30;
    step();
    check_port("b2b_1", 0, 32'h1, 1'b1);
    wr(1, 6'd30, 32'h2);
    wr_en[0] = 1'b0;
    step();
    check_port("b2b_2", 0, 32'h2, 1'b1);

    // Mid-stream reset discards the in-flight write and restores all state.
    idle();
    reset_n = 1'b0;
    wr(0, 6'd7, 32'h1234);
    rd_all(6'd7);
    step();
    check_all("mrst", 32'h0, 1'b1);
    reset_n = 1'b1;
    idle();
    rd_addr[0*ADDR_W +: ADDR_W] = 6'd7;
    rd_addr[1*ADDR_W +: ADDR_W] = 6'd20;
    rd_addr[2*ADDR_W +: ADDR_W] = 6'd12;
    rd_addr[3*ADDR_W +: ADDR_W] = 6'd40;
    step();
    check_port("mrst_p7", 0, 32'h0, 1'b1);
    check_port("mrst_p20", 1, 32'h0, 1'b1);
    check_port("mrst_p12", 2, 32'h0, 1'b1);
    check_port("mrst_p40", 3, 32'h0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/prf_multiport.md
# prf_multiport

Parametrised physical register file for the out-of-order core. It provides NUM_RD registered read ports and NUM_WR write ports with same-cycle write-to-read bypass. It also holds a per-register ready (scoreboard) bit: the bit is cleared when rename allocates a register and set again on writeback. It sits between rename/issue (reads, allocations) and the writeback buses (writes).

## Interface
- DATA_W, 32, register width in bits
- NUM_PREGS, 64, number of physical registers; power of two, ≥ 2
- NUM_RD, 4, number of read ports
- NUM_WR, 2, number of write ports
- NUM_ALLOC, 2, number of allocation (busy-set) ports
- ADDR_W, $clog2(NUM_PREGS), derived; not overridden
- clk  in  1  single clock; all state updates on posedge
- reset_n  in  1  synchronous, active-low reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  registered read data, same packing
- rd_ready  out  NUM_RD  registered ready bit of each addressed register
- wr_en  in  NUM_WR  per-port write enable
- wr_addr  in  NUM_WR*ADDR_W  write addresses
- wr_data  in  NUM_WR*DATA_W  write data
- alloc_en  in  NUM_ALLOC  per-port allocate strobe; clears ready
- alloc_addr  in  NUM_ALLOC*ADDR_W  allocated register addresses

## Operation
- Storage: NUM_PREGS × DATA_W data array plus NUM_PREGS ready bits.
- Reset (reset_n=0 at posedge): all data = 0, all ready = 1, rd_data = 0, rd_ready = all 1s. Reset takes priority over every other input.
- Register 0:
  - Data is permanently 0 and ready is permanently 1.
  - Writes and allocations to address 0 are discarded.
  - Reads of address 0 return 0 and ready = 1, including under bypass.
- Write: when wr_en[j] is high and wr_addr[j] != 0, data[wr_addr[j]] <= wr_data[j] and ready[wr_addr[j]] <= 1.
- Allocate: when alloc_en[k] is high and alloc_addr[k] != 0, ready[alloc_addr[k]] <= 0. Data is unchanged.
- Same-cycle conflicts, resolved per address:
  - Several write ports to the same address: the highest-indexed port's data wins.
  - Allocate and write to the same address: the data write happens; ready ends at 0 (allocate wins).
  - Several allocates to the same address: same as one.
- Read with bypass: rd_data[i] and rd_ready[i] are registered from the post-update view of rd_addr[i] in the same cycle. Same-cycle writes and allocates are visible, using the conflict rules above.
- No handshake; every port is accepted every cycle. Upstream guarantees no allocation of a register still in flight.

## Timing
- Read latency is 1 cycle: address presented at edge t appears on rd_data/rd_ready after edge t+1.
- Write latency is 0 cycles to a same-cycle read (bypass). Data is stored at the edge.
- Allocate is visible as rd_ready = 0 on a same-cycle read of that address, i.e. on the outputs after the edge.
- Back-to-back writes to the same address on consecutive cycles: each cycle's read reflects that cycle's write.
- Reset asserted mid-stream: on the next edge all state and outputs take reset values and any in-flight write is lost. The first cycle with reset_n=1 accepts traffic normally.
- All outputs come directly from flops; no combinational path from inputs to outputs.

## Test plan
- Reset: hold reset_n=0 two cycles with wr_en=all 1s to addr 5 → after release, reading addr 5 gives rd_data=0 and rd_ready=1; all rd_data=0.
- Basic R/W: write 0xDEADBEEF to p7 on port 0 at cycle t, read p7 on all ports at t+1 → all rd_data = 0xDEADBEEF one cycle later.
- Bypass and priority: write 0x11 (port 0) and 0x22 (port 1) to p9, and read p9, all in the same cycle → rd_data = 0x22 next cycle; a later read also gives 0x22.
- Scoreboard: allocate p12 at t, read p12 at t+1 → rd_ready=0. Then at t+3 write 0x5 to p12 and read p12 in the same cycle → rd_ready=1, rd_data=0x5.
- Allocate-vs-write: allocate and write 0xAA to p20 in the same cycle → read gives rd_data=0xAA, rd_ready=0.
- p0 guard: write 0xFFFFFFFF and allocate addr 0 together → read p0 gives 0 with rd_ready=1, both same-cycle and later.
